pk_link: RTL
============

Name: pk_link

Overview:
- Parametrised command/status engine for the control panel serial link; sits between the UART (byte-level rx strobe, tx send/busy) and the panel logic.
- Decodes received command bytes into data keys, function keys and the rotary position.
- Returns a coherent multi-byte status frame on request, or automatically when status changes.
- Generalises the fixed 4-byte panel protocol: per-key momentary/latched mask, timed momentary pulses, queued requests, auto-report, and a tx watchdog.

Parameters:
FN_N, 12, number of function keys (max 16)
MOMENTARY_MASK, 12'b1111_1111_1000, bit i=1 means fnkey[i] self-clears
PULSE_TICKS, 20, clock cycles a momentary key stays asserted (>=1)
N_STAT, 4, status frame length in bytes (1..16)
TX_TIMEOUT, 1000, cycles to wait for tx_busy rising before aborting a byte

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_byte  in  8  received byte, valid with rx_valid
rx_valid  in  1  one-cycle strobe, new byte received
tx_busy  in  1  UART transmitter busy
tx_byte  out  8  byte to transmit, stable while tx_send=1
tx_send  out  1  transmit request level
status  in  8*N_STAT  status bytes; byte k = status[8k+7:8k], byte 0 sent first
keys  out  16  data keys
fnkey  out  FN_N  function key states
rotary_pos  out  4  last rotary position
auto_en  out  1  auto-report enabled
tx_err  out  1  sticky; set on tx watchdog abort

Behaviour:
- Reset: keys=0, fnkey=0, rotary_pos=4'b0001, auto_en=0, tx_err=0, tx_send=0, tx_byte=0, pending=0, sender IDLE, pulse counters 0.
- Command decode on rx_valid by rx_byte[7:5]; all updates visible the next cycle:
  - 000: rx_byte[4:1]==0 sets auto_en<=rx_byte[0]; other values are ignored.
  - 001: idx=rx_byte[4:1]. If idx<FN_N, fnkey[idx]<=rx_byte[0]; if idx>=FN_N, no effect.
  - 010/011: keys[5:0]<=rx_byte[5:0].
  - 100: keys[10:6]<=rx_byte[4:0].
  - 101: keys[15:11]<=rx_byte[4:0].
  - 110: status request; sets pending.
  - 111: rotary_pos<=rx_byte[3:0].
- Momentary keys (MOMENTARY_MASK[i]=1):
  - Set to 1 loads a per-key counter with PULSE_TICKS; key held exactly PULSE_TICKS cycles, then cleared by hardware.
  - Re-set while active reloads the counter.
  - Explicit set to 0 clears the key and its counter immediately.
  - Latched keys change only by command.
- Sender FSM IDLE -> LOAD -> WAIT_BUSY -> WAIT_DONE:
  - IDLE: if pending and ~tx_busy: snapshot whole status vector to shadow register, b_cnt<=0, pending<=0, -> LOAD.
  - LOAD: tx_byte<=shadow byte b_cnt, tx_send<=1, watchdog<=0, -> WAIT_BUSY.
  - WAIT_BUSY: on tx_busy=1: tx_send<=0, -> WAIT_DONE. If watchdog reaches TX_TIMEOUT first: tx_send<=0, tx_err<=1, -> IDLE (frame abandoned; pending untouched).
  - WAIT_DONE: on tx_busy=0: if b_cnt==N_STAT-1 -> IDLE, else b_cnt+1 and -> LOAD.
- Frame coherence: bytes come from the snapshot; status changes mid-frame do not alter the frame.
- Request queuing: one-deep. A request during a frame sets pending and gives exactly one further frame; several requests during a frame still give one.
- Auto-report:
  - Compares status with the last sent snapshot; a difference raises pending when auto_en=1 and the sender is IDLE.
  - Before the first frame after reset the last-snapshot register is 0.
- Simultaneous events:
  - A command and a momentary expiry on the same key: the command wins.
  - A request and frame completion on the same cycle: the request stays pending.
- rst mid-frame: tx_send drops the next cycle and the FSM returns to IDLE. Any partly sent UART byte is the UART's concern.

Test Plan:
- Keys: rx 0x55, 0x9F, 0xA3 -> keys=16'b00011_11111_010101 (0x1FD5).
- Momentary: rx 0x27 (fnkey[3]=1), PULSE_TICKS=20 -> fnkey[3]=1 for exactly 20 cycles, then 0. rx 0x21 (fnkey[0]=1) -> stays 1 indefinitely. rx 0x3F (idx 15 >= FN_N) -> no change.
- Status frame: status=0x44_33_22_11, rx 0xC0, UART model busy 10 cycles per byte -> tx_byte sequence 0x11, 0x22, 0x33, 0x44, one tx_send rise each. Change status to all 0xFF after byte 0 -> remaining bytes still 0x22, 0x33, 0x44.
- Queuing: three 0xC0 during a frame -> exactly two frames total, second with fresh snapshot.
- Auto-report: rx 0x01, change status byte 2 -> one frame with no request; unchanged status -> no further frames; rx 0x00, change status -> no frame.
- Watchdog + reset: hold tx_busy=0 after send, TX_TIMEOUT=1000 -> tx_send drops at cycle 1000, tx_err=1. Assert rst mid-frame -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/pk_link.sv
// ---------------------------------------------------------------------------
// pk_link -- command/status engine for the control panel serial link.
//
// Sits between a byte-level UART and the panel logic. Received command
// bytes update the data keys, function keys, rotary position and the
// auto-report enable. A status frame of N_STAT bytes is sent back on
// request, or automatically when the status vector differs from the last
// frame sent. Momentary function keys clear themselves after PULSE_TICKS
// cycles; a watchdog abandons a frame if the UART never goes busy.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   rx_byte_i    received byte, valid with rx_valid_i
//   rx_valid_i   one-cycle strobe, new byte received
//   tx_busy_i    UART transmitter busy
//   tx_byte_o    byte to transmit, stable while tx_send_o=1
//   tx_send_o    transmit request level
//   status_i     status bytes, byte k = status_i[8k+7:8k], byte 0 sent first
//   keys_o       data keys
//   fnkey_o      function key states
//   rotary_pos_o last rotary position
//   auto_en_o    auto-report enabled
//   tx_err_o     sticky, set when the tx watchdog abandons a frame
// ---------------------------------------------------------------------------
module pk_link #(
    parameter int                FN_N           = 12,
    parameter logic [FN_N-1:0]   MOMENTARY_MASK = 12'b1111_1111_1000,
    parameter int                PULSE_TICKS    = 20,
    parameter int                N_STAT         = 4,
    parameter int                TX_TIMEOUT     = 1000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            rx_byte_i,
    input  logic                  rx_valid_i,
    input  logic                  tx_busy_i,
    output logic [7:0]            tx_byte_o,
    output logic                  tx_send_o,
    input  logic [8*N_STAT-1:0]   status_i,
    output logic [15:0]           keys_o,
    output logic [FN_N-1:0]       fnkey_o,
    output logic [3:0]            rotary_pos_o,
    output logic                  auto_en_o,
    output logic                  tx_err_o
);

    localparam int PW = (PULSE_TICKS < 1) ? 1 : $clog2(PULSE_TICKS + 1);
    localparam int WW = (TX_TIMEOUT  < 2) ? 1 : $clog2(TX_TIMEOUT + 1);
    localparam int BW = (N_STAT      < 2) ? 1 : $clog2(N_STAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    // Command fields
    logic [2:0] cmd;
    logic [3:0] fn_idx;
    logic       fn_cmd;
    logic       req_cmd;
    logic       auto_diff;

    assign cmd     = rx_byte_i[7:5];
    assign fn_idx  = rx_byte_i[4:1];
    assign fn_cmd  = rx_valid_i && (cmd == 3'b001);
    assign req_cmd = rx_valid_i && (cmd == 3'b110);

    // Registers
    logic [15:0]          keys_q;
    logic [3:0]           rotary_q;
    logic                 auto_en_q;
    logic [FN_N-1:0]      fnkey_q, fnkey_d;
    logic [PW-1:0]        pcnt_q [FN_N];
    logic [PW-1:0]        pcnt_d [FN_N];

    state_t               state_q;
    logic                 pending_q;
    logic [8*N_STAT-1:0]  shadow_q;
    logic [BW-1:0]        b_cnt_q;
    logic [WW-1:0]        wd_q;
    logic [7:0]           tx_byte_q;
    logic                 tx_send_q;
    logic                 tx_err_q;

    // Auto-report only looks while the sender is idle; the shadow register
    // doubles as the "last frame sent" reference.
    assign auto_diff = auto_en_q && (state_q == S_IDLE) && (status_i != shadow_q);

    // Data keys, rotary position and auto-report enable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            keys_q    <= '0;
            rotary_q  <= 4'b0001;
            auto_en_q <= 1'b0;
        end else if (rx_valid_i) begin
            case (cmd)
                3'b000: if (rx_byte_i[4:1] == 4'b0000) auto_en_q <= rx_byte_i[0];
                3'b010,
                3'b011: keys_q[5:0]   <= rx_byte_i[5:0];
                3'b100: keys_q[10:6]  <= rx_byte_i[4:0];
                3'b101: keys_q[15:11] <= rx_byte_i[4:0];
                3'b111: rotary_q      <= rx_byte_i[3:0];
                default: ;
            endcase
        end
    end

    // Function keys: momentary expiry is evaluated first so that a command
    // to the same key in the same cycle overrides it. An index beyond FN_N
    // matches no loop iteration and is therefore ignored.
    always_comb begin
        fnkey_d = fnkey_q;
        for (int i = 0; i < FN_N; i++) begin
            pcnt_d[i] = pcnt_q[i];
            if (MOMENTARY_MASK[i] && (pcnt_q[i] != '0)) begin
                if (pcnt_q[i] == PW'(1)) begin
                    fnkey_d[i] = 1'b0;
                    pcnt_d[i]  = '0;
                end else begin
                    pcnt_d[i] = pcnt_q[i] - PW'(1);
                end
            end
            if (fn_cmd && (fn_idx == 4'(i))) begin
                fnkey_d[i] = rx_byte_i[0];
                if (MOMENTARY_MASK[i]) begin
                    pcnt_d[i] = rx_byte_i[0] ? PW'(PULSE_TICKS) : '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fnkey_q <= '0;
            for (int i = 0; i < FN_N; i++) pcnt_q[i] <= '0;
        end else begin
            fnkey_q <= fnkey_d;
            for (int i = 0; i < FN_N; i++) pcnt_q[i] <= pcnt_d[i];
        end
    end

    // Sender FSM. Pending is set by a request or an auto-report difference;
    // starting a frame clears it unless a new request arrives in that same
    // cycle, which keeps the one-deep request queue lossless.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            shadow_q  <= '0;
            b_cnt_q   <= '0;
            wd_q      <= '0;
            tx_byte_q <= '0;
            tx_send_q <= 1'b0;
            tx_err_q  <= 1'b0;
        end else begin
            if (req_cmd || auto_diff) pending_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (pending_q && !tx_busy_i) begin
                        shadow_q  <= status_i;
                        b_cnt_q   <= '0;
                        pending_q <= req_cmd;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_byte_q <= shadow_q[8*b_cnt_q +: 8];
                    tx_send_q <= 1'b1;
                    wd_q      <= '0;
                    state_q   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        tx_send_q <= 1'b0;
                        state_q   <= S_WAIT_DONE;
                    end else if (wd_q == WW'(TX_TIMEOUT - 1)) begin
                        tx_send_q <= 1'b0;
                        tx_err_q  <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + WW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        if (b_cnt_q == BW'(N_STAT - 1)) begin
                            state_q <= S_IDLE;
                        end else begin
                            b_cnt_q <= b_cnt_q + BW'(1);
                            state_q <= S_LOAD;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign keys_o       = keys_q;
    assign fnkey_o      = fnkey_q;
    assign rotary_pos_o = rotary_q;
    assign auto_en_o    = auto_en_q;
    assign tx_byte_o    = tx_byte_q;
    assign tx_send_o    = tx_send_q;
    assign tx_err_o     = tx_err_q;

endmodule
